multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/mips_pkg.sv | 67 ++++++
 rtl/mc_alu_decoder.sv | 39 +++
 rtl/multicycle_controller.sv | 161 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package : mips_pkg
// Brief   : Opcode, funct, ALU-control, mux-select and state codes shared by
//           the multicycle controller and its ALU decoder.
// Rev     : 1.0
// ============================================================================
package mips_pkg;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;

    localparam logic [5:0] c_fn_add = 6'b100000;
    localparam logic [5:0] c_fn_sub = 6'b100010;
    localparam logic [5:0] c_fn_and = 6'b100100;
    localparam logic [5:0] c_fn_or  = 6'b100101;
    localparam logic [5:0] c_fn_slt = 6'b101010;
    localparam logic [5:0] c_fn_sll = 6'b000000;
    localparam logic [5:0] c_fn_srl = 6'b000010;

    localparam logic [3:0] c_alu_and = 4'b0000;
    localparam logic [3:0] c_alu_or  = 4'b0001;
    localparam logic [3:0] c_alu_add = 4'b0010;
    localparam logic [3:0] c_alu_sub = 4'b0110;
    localparam logic [3:0] c_alu_slt = 4'b0111;
    localparam logic [3:0] c_alu_sll = 4'b1000;
    localparam logic [3:0] c_alu_srl = 4'b1001;

    localparam logic [1:0] c_srcb_rd2    = 2'b00;
    localparam logic [1:0] c_srcb_four   = 2'b01;
    localparam logic [1:0] c_srcb_imm    = 2'b10;
    localparam logic [1:0] c_srcb_imm_sh = 2'b11;

    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECUTE  = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_ADDIEXEC = 4'd9,
        ST_ADDIWB   = 4'd10,
        ST_JUMP     = 4'd11
    } state_t;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            c_op_rtype, c_op_lw, c_op_sw, c_op_beq,
            c_op_bne, c_op_addi, c_op_j: op_supported = 1'b1;
            default:                     op_supported = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module : mc_alu_decoder
// Brief  : R-type funct field to ALU control, shift select and validity flag.
// Rev    : 1.0
// ============================================================================
module mc_alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_control,
    output logic       o_shift,
    output logic       o_valid
);

    always_comb begin
        o_alu_control = c_alu_add;
        o_shift       = 1'b0;
        o_valid       = 1'b1;
        case (i_funct)
            c_fn_add: o_alu_control = c_alu_add;
            c_fn_sub: o_alu_control = c_alu_sub;
            c_fn_and: o_alu_control = c_alu_and;
            c_fn_or:  o_alu_control = c_alu_or;
            c_fn_slt: o_alu_control = c_alu_slt;
            c_fn_sll: begin
                o_alu_control = c_alu_sll;
                o_shift       = 1'b1;
            end
            c_fn_srl: begin
                o_alu_control = c_alu_srl;
                o_shift       = 1'b1;
            end
            default:  o_valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module : multicycle_controller
// Brief  : Multicycle MIPS control FSM with MEM_WAIT wait states per memory access.
// Rev    : 1.0
// ============================================================================
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic       i_clk,
    input  logic       i_arst,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_zero,
    output logic       o_pc_write,
    output logic       o_ir_write,
    output logic       o_mem_write,
    output logic       o_reg_write,
    output logic       o_iord,
    output logic       o_reg_dst,
    output logic       o_memto_reg,
    output logic       o_alu_src_a,
    output logic       o_shift,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_pc_src,
    output logic [3:0] o_alu_control,
    output logic [3:0] o_state,
    output logic       o_illegal
);

    localparam logic [3:0] c_wait_last = MEM_WAIT[3:0];

    state_t     r_state;
    logic [3:0] r_wait_cnt;
    logic       w_mem_state;
    logic       w_wait_done;
    logic [3:0] w_fn_alu;
    logic       w_fn_shift;
    logic       w_fn_valid;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_illegal;

    mc_alu_decoder u_alu_dec (
        .i_funct       (i_funct),
        .o_alu_control (w_fn_alu),
        .o_shift       (w_fn_shift),
        .o_valid       (w_fn_valid)
    );

    assign w_mem_state = (r_state == ST_FETCH) || (r_state == ST_MEMREAD) ||
                         (r_state == ST_MEMWRITE);
    assign w_wait_done = (r_wait_cnt == c_wait_last);

    // Memory states hold until the counter reaches MEM_WAIT; every exit clears it.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            r_state    <= ST_FETCH;
            r_wait_cnt <= '0;
        end else if (w_mem_state && !w_wait_done) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end else begin
            r_wait_cnt <= '0;
            case (r_state)
                ST_FETCH:    r_state <= ST_DECODE;
                ST_DECODE: begin
                    case (i_opcode)
                        c_op_lw, c_op_sw:   r_state <= ST_MEMADR;
                        c_op_rtype:         r_state <= ST_EXECUTE;
                        c_op_beq, c_op_bne: r_state <= ST_BRANCH;
                        c_op_addi:          r_state <= ST_ADDIEXEC;
                        c_op_j:             r_state <= ST_JUMP;
                        default:            r_state <= ST_FETCH;
                    endcase
                end
                ST_MEMADR:   r_state <= (i_opcode == c_op_lw) ? ST_MEMREAD : ST_MEMWRITE;
                ST_MEMREAD:  r_state <= ST_MEMWB;
                ST_EXECUTE:  r_state <= w_fn_valid ? ST_ALUWB : ST_FETCH;
                ST_ADDIEXEC: r_state <= ST_ADDIWB;
                default:     r_state <= ST_FETCH;
            endcase
        end
    end

    always_comb begin
        w_pc_write    = 1'b0;
        w_ir_write    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_illegal     = 1'b0;
        o_iord        = 1'b0;
        o_reg_dst     = 1'b0;
        o_memto_reg   = 1'b0;
        o_alu_src_a   = 1'b0;
        o_shift       = 1'b0;
        o_alu_src_b   = c_srcb_rd2;
        o_pc_src      = c_pcsrc_alu;
        o_alu_control = c_alu_add;
        case (r_state)
            ST_FETCH: begin
                o_alu_src_b = c_srcb_four;
                w_pc_write  = w_wait_done;
                w_ir_write  = w_wait_done;
            end
            ST_DECODE: begin
                o_alu_src_b = c_srcb_imm_sh;
                w_illegal   = !op_supported(i_opcode);
            end
            ST_MEMADR, ST_ADDIEXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = c_srcb_imm;
            end
            ST_MEMREAD:  o_iord = 1'b1;
            ST_MEMWRITE: begin
                o_iord      = 1'b1;
                w_mem_write = w_wait_done;
            end
            ST_MEMWB: begin
                o_memto_reg = 1'b1;
                w_reg_write = 1'b1;
            end
            ST_EXECUTE: begin
                o_alu_src_a   = 1'b1;
                o_alu_control = w_fn_alu;
                o_shift       = w_fn_shift;
                w_illegal     = !w_fn_valid;
            end
            ST_ALUWB: begin
                o_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
            end
            ST_BRANCH: begin
                o_alu_src_a   = 1'b1;
                o_alu_control = c_alu_sub;
                o_pc_src      = c_pcsrc_aluout;
                w_pc_write    = ((i_opcode == c_op_beq) && i_zero) ||
                                ((i_opcode == c_op_bne) && !i_zero);
            end
            ST_ADDIWB:   w_reg_write = 1'b1;
            ST_JUMP: begin
                o_pc_src   = c_pcsrc_jump;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are masked while reset is low so nothing fires from the held FETCH state.
    assign o_pc_write  = w_pc_write  & i_arst;
    assign o_ir_write  = w_ir_write  & i_arst;
    assign o_mem_write = w_mem_write & i_arst;
    assign o_reg_write = w_reg_write & i_arst;
    assign o_illegal   = w_illegal   & i_arst;
    assign o_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_multicycle_controller
// Brief  : Scoreboard bench for multicycle_controller at MEM_WAIT 0 and 2.
// Rev    : 1.0
// ============================================================================
module tb_multicycle_controller;

    typedef struct packed {
        logic [3:0] state;
        logic       pcw, irw, mw, rw, iord, rdst, m2r, sa, sh;
        logic [1:0] sb, ps;
        logic [3:0] alu;
        logic       ill;
    } exp_t;

    localparam logic [3:0] c_and = 4'b0000;
    localparam logic [3:0] c_or  = 4'b0001;
    localparam logic [3:0] c_add = 4'b0010;
    localparam logic [3:0] c_sub = 4'b0110;
    localparam logic [3:0] c_slt = 4'b0111;
    localparam logic [3:0] c_sll = 4'b1000;
    localparam logic [3:0] c_srl = 4'b1001;

    logic       clk = 1'b0;
    logic       arst, zero;
    logic [5:0] opcode, funct;
    logic       nx_arst, nx_z;
    logic [5:0] nx_op, nx_fn;

    logic [1:0]      pcw, irw, mw, rw, iord, rdst, m2r, sa, sh, ill;
    logic [1:0][1:0] sb, ps;
    logic [1:0][3:0] alu, st;

    exp_t  q_exp[$];
    bit    q_sel[$];
    string q_name[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    logic [5:0] fn_tab  [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b101010, 6'b000000, 6'b000010};
    logic [3:0] alu_tab [7] = '{c_add, c_sub, c_and, c_or, c_slt, c_sll, c_srl};
    logic       sh_tab  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_WAIT(0)) u_dut0 (
        .i_clk(clk), .i_arst(arst), .i_opcode(opcode), .i_funct(funct), .i_zero(zero),
        .o_pc_write(pcw[0]), .o_ir_write(irw[0]), .o_mem_write(mw[0]), .o_reg_write(rw[0]),
        .o_iord(iord[0]), .o_reg_dst(rdst[0]), .o_memto_reg(m2r[0]), .o_alu_src_a(sa[0]),
        .o_shift(sh[0]), .o_alu_src_b(sb[0]), .o_pc_src(ps[0]), .o_alu_control(alu[0]),
        .o_state(st[0]), .o_illegal(ill[0])
    );

    multicycle_controller #(.MEM_WAIT(2)) u_dut2 (
        .i_clk(clk), .i_arst(arst), .i_opcode(opcode), .i_funct(funct), .i_zero(zero),
        .o_pc_write(pcw[1]), .o_ir_write(irw[1]), .o_mem_write(mw[1]), .o_reg_write(rw[1]),
        .o_iord(iord[1]), .o_reg_dst(rdst[1]), .o_memto_reg(m2r[1]), .o_alu_src_a(sa[1]),
        .o_shift(sh[1]), .o_alu_src_b(sb[1]), .o_pc_src(ps[1]), .o_alu_control(alu[1]),
        .o_state(st[1]), .o_illegal(ill[1])
    );

    function automatic exp_t act(input bit k);
        act = {st[k], pcw[k], irw[k], mw[k], rw[k], iord[k], rdst[k], m2r[k], sa[k], sh[k],
               sb[k], ps[k], alu[k], ill[k]};
    endfunction

    function automatic exp_t mk(input logic [3:0] s, input logic p_pcw, p_irw, p_mw, p_rw,
                                input logic p_iord, p_rdst, p_m2r, p_sa, p_sh,
                                input logic [1:0] p_sb, p_ps, input logic [3:0] p_alu,
                                input logic p_ill);
        mk = {s, p_pcw, p_irw, p_mw, p_rw, p_iord, p_rdst, p_m2r, p_sa, p_sh,
              p_sb, p_ps, p_alu, p_ill};
    endfunction

    // Hand-written expected output vector for each state.
    function automatic exp_t f_fetch(input logic fin);
        f_fetch = mk(4'd0, fin, fin, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, c_add, 0);
    endfunction
    function automatic exp_t f_decode(input logic il);
        f_decode = mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, c_add, il);
    endfunction
    function automatic exp_t f_memadr();
        f_memadr = mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, c_add, 0);
    endfunction
    function automatic exp_t f_memread();
        f_memread = mk(4'd3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, c_add, 0);
    endfunction
    function automatic exp_t f_memwb();
        f_memwb = mk(4'd4, 0, 0, 0, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, c_add, 0);
    endfunction
    function automatic exp_t f_memwrite(input logic fin);
        f_memwrite = mk(4'd5, 0, 0, fin, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, c_add, 0);
    endfunction
    function automatic exp_t f_execute(input logic [3:0] a, input logic s, input logic il);
        f_execute = mk(4'd6, 0, 0, 0, 0, 0, 0, 0, 1, s, 2'b00, 2'b00, a, il);
    endfunction
    function automatic exp_t f_aluwb();
        f_aluwb = mk(4'd7, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, c_add, 0);
    endfunction
    function automatic exp_t f_branch(input logic p);
        f_branch = mk(4'd8, p, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, c_sub, 0);
    endfunction
    function automatic exp_t f_addiexec();
        f_addiexec = mk(4'd9, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b00, c_add, 0);
    endfunction
    function automatic exp_t f_addiwb();
        f_addiwb = mk(4'd10, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, c_add, 0);
    endfunction
    function automatic exp_t f_jump();
        f_jump = mk(4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, c_add, 0);
    endfunction

    // One clock cycle: apply the pending inputs just after the edge, queue the expectation.
    task automatic vec(input bit sel, input exp_t e, input string name);
        @(posedge clk);
        #1;
        arst   = nx_arst;
        opcode = nx_op;
        funct  = nx_fn;
        zero   = nx_z;
        q_exp.push_back(e);
        q_sel.push_back(sel);
        q_name.push_back(name);
    endtask

    initial begin : monitor
        exp_t  e;
        exp_t  a;
        bit    k;
        string nm;
        forever begin
            @(negedge clk);
            if (q_exp.size() != 0) begin
                e  = q_exp.pop_front();
                k  = q_sel.pop_front();
                nm = q_name.pop_front();
                a  = act(k);
                n_checks++;
                if (a === e) n_pass++;
                else $display("FAIL %s (MEM_WAIT=%0d): got %h state %0d, expected %h state %0d",
                              nm, k ? 2 : 0, a, a.state, e, e.state);
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL timeout: simulation exceeded 50000 time units");
        $fatal(1);
    end

    initial begin : stimulus
        arst = 1'b0; opcode = '0; funct = '0; zero = 1'b0;
        nx_arst = 1'b0; nx_op = '0; nx_fn = '0; nx_z = 1'b0;

        vec(0, f_fetch(0), "reset_d0");
        vec(1, f_fetch(0), "reset_d2");

        nx_arst = 1'b1; nx_op = 6'b100011;
        vec(0, f_fetch(1), "lw_fetch");
        vec(0, f_decode(0), "lw_decode");
        vec(0, f_memadr(), "lw_memadr");
        vec(0, f_memread(), "lw_memread");
        vec(0, f_memwb(), "lw_memwb");

        nx_op = 6'b101011;
        vec(0, f_fetch(1), "sw_fetch");
        vec(0, f_decode(0), "sw_decode");
        vec(0, f_memadr(), "sw_memadr");
        vec(0, f_memwrite(1), "sw_memwrite");

        for (int i = 0; i < 7; i++) begin
            nx_op = 6'b000000; nx_fn = fn_tab[i];
            vec(0, f_fetch(1), $sformatf("r%b_fetch", fn_tab[i]));
            vec(0, f_decode(0), $sformatf("r%b_decode", fn_tab[i]));
            vec(0, f_execute(alu_tab[i], sh_tab[i], 1'b0), $sformatf("r%b_execute", fn_tab[i]));
            vec(0, f_aluwb(), $sformatf("r%b_aluwb", fn_tab[i]));
        end

        nx_fn = 6'b111111;
        vec(0, f_fetch(1), "badfn_fetch");
        vec(0, f_decode(0), "badfn_decode");
        vec(0, f_execute(c_add, 1'b0, 1'b1), "badfn_execute");

        nx_op = 6'b001000;
        vec(0, f_fetch(1), "addi_fetch");
        vec(0, f_decode(0), "addi_decode");
        vec(0, f_addiexec(), "addi_exec");
        vec(0, f_addiwb(), "addi_wb");

        for (int i = 0; i < 4; i++) begin
            nx_op = (i < 2) ? 6'b000100 : 6'b000101;
            nx_z  = (i % 2 == 0);
            vec(0, f_fetch(1), $sformatf("br%0d_fetch", i));
            vec(0, f_decode(0), $sformatf("br%0d_decode", i));
            vec(0, f_branch((i == 0) || (i == 3)), $sformatf("br%0d_branch", i));
        end

        nx_op = 6'b000010;
        vec(0, f_fetch(1), "j_fetch");
        vec(0, f_decode(0), "j_decode");
        vec(0, f_jump(), "j_jump");

        nx_op = 6'b111111;
        vec(0, f_fetch(1), "ill3f_fetch");
        vec(0, f_decode(1), "ill3f_decode");
        nx_op = 6'b001100;
        vec(0, f_fetch(1), "ill0c_fetch");
        vec(0, f_decode(1), "ill0c_decode");

        nx_op = 6'b100011;
        vec(0, f_fetch(1), "lwrst_fetch");
        vec(0, f_decode(0), "lwrst_decode");
        vec(0, f_memadr(), "lwrst_memadr");
        vec(0, f_memread(), "lwrst_memread");
        nx_arst = 1'b0;
        vec(0, f_fetch(0), "reset_in_memwb");
        vec(0, f_fetch(0), "reset_hold");
        nx_arst = 1'b1; nx_op = 6'b000010;
        vec(0, f_fetch(1), "post_reset_fetch");
        vec(0, f_decode(0), "post_reset_decode");
        vec(0, f_jump(), "post_reset_jump");

        nx_arst = 1'b0;
        vec(1, f_fetch(0), "d2_reset");
        nx_arst = 1'b1; nx_op = 6'b101011;
        vec(1, f_fetch(0), "d2_sw_fetch0");
        vec(1, f_fetch(0), "d2_sw_fetch1");
        vec(1, f_fetch(1), "d2_sw_fetch2");
        vec(1, f_decode(0), "d2_sw_decode");
        vec(1, f_memadr(), "d2_sw_memadr");
        vec(1, f_memwrite(0), "d2_sw_memwrite0");
        vec(1, f_memwrite(0), "d2_sw_memwrite1");
        vec(1, f_memwrite(1), "d2_sw_memwrite2");
        nx_op = 6'b100011;
        vec(1, f_fetch(0), "d2_lw_fetch0");
        vec(1, f_fetch(0), "d2_lw_fetch1");
        vec(1, f_fetch(1), "d2_lw_fetch2");
        vec(1, f_decode(0), "d2_lw_decode");
        vec(1, f_memadr(), "d2_lw_memadr");
        vec(1, f_memread(), "d2_lw_memread0");
        vec(1, f_memread(), "d2_lw_memread1");
        vec(1, f_memread(), "d2_lw_memread2");
        vec(1, f_memwb(), "d2_lw_memwb");
        vec(1, f_fetch(0), "d2_next_fetch");

        repeat (2) @(posedge clk);
        n_checks++;
        if (q_exp.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left unchecked, required 0", q_exp.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
